// File: rtl/imem_responder.sv
// ============================================================================
// imem_responder : fixed-latency instruction memory with valid/ready handshake
// Revision 1.0
// ============================================================================
`default_nettype none

module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int          c_IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);
    localparam logic [29:0] c_DEPTH    = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic [31:0] r_mem [0:DEPTH_WORDS-1];

    logic w_req_err;
    logic w_load_ok;

    assign w_req_err = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= c_DEPTH);
    assign w_load_ok = (load_addr[1:0] == 2'b00) && (load_addr[31:2] < c_DEPTH);

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_resp_data <= 32'd0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        // Read and a same-edge load race: the read sees the pre-write word.
                        r_resp_data <= w_req_err ? c_NOP : r_mem[r_addr[2 +: c_IDX_W]];
                        r_resp_err  <= w_req_err;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Program memory survives reset, so loads are accepted regardless of rst.
    always_ff @(posedge clk) begin
        if (load_en && w_load_ok) begin
            r_mem[load_addr[2 +: c_IDX_W]] <= load_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
// ============================================================================
// tb_imem_responder : randomized self-checking bench with a transaction model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_imem_responder;

    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, resp_data;
    logic        load_en;
    logic [31:0] load_addr, load_data;

    logic        req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1, resp_data1;

    logic [31:0] ref_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_data(resp_data1), .resp_err(resp_err1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    function automatic void apply_load(input logic [31:0] a, input logic [31:0] d);
        if (a[1:0] == 2'b00 && (a >> 2) < 32'(DEPTH)) ref_mem[a[9:2]] = d;
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom;
        if (r == 1) return {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
        return {22'h0, 8'($urandom), 2'b00};
    endfunction

    // One clock edge; any load presented is committed to the model at that edge.
    task automatic step();
        if (load_en) apply_load(load_addr, load_data);
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic txn(input logic [31:0] addr, input int hold);
        logic [31:0] ed;
        logic        ee;
        logic [31:0] la;
        ed = 32'd0;
        ee = is_err(addr);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;
        check("accepted_req_ready", 32'(req_ready), 32'd0);
        for (int c = 1; c <= LAT; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                la        = {22'h0, 8'($urandom), 2'b00};
                load_en   = 1'b1;
                load_addr = ($urandom_range(0, 1) == 1) ? {addr[31:2], 2'b00} : la;
                load_data = $urandom;
            end
            if (c == LAT) ed = ee ? NOP : ref_mem[addr[9:2]];
            step();
            req_addr = $urandom;
            check("resp_valid_timing", 32'(resp_valid), 32'(c == LAT));
        end
        for (int h = 0; h <= hold; h++) begin
            check("resp_valid_hold", 32'(resp_valid), 32'd1);
            check("resp_data", resp_data, ed);
            check("resp_err", 32'(resp_err), 32'(ee));
            check("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (h < hold) begin
                resp_ready = 1'b0;
                step();
            end
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("back_to_idle_ready", 32'(req_ready), 32'd1);
        check("back_to_idle_valid", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int last_acc;
        int n_acc;
        logic [31:0] cap;
        logic [31:0] old_w;
        logic [31:0] new_w;
        bit idle;

        rst = 1'b0;
        req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b0;
        req_valid1 = 1'b0; req_addr1 = 32'd0; resp_ready1 = 1'b0;
        load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0;

        // Program memory while held in reset; loads are not gated by reset.
        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i) << 2;
            load_data = (i == 3) ? 32'h0050_0093 : $urandom;
            step();
        end
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);

        rst = 1'b1;
        txn(32'h0000_000C, 0);
        txn(32'h0000_0006, 0);
        txn(32'h0000_0400, 0);
        txn(32'h0000_000C, 5);

        for (int n = 0; n < 30; n++) txn(rand_addr(), $urandom_range(0, 3));

        // Continuous requests with a changing address and immediate consumption.
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        last_acc   = -1;
        n_acc      = 0;
        cap        = 32'd0;
        for (int t = 0; t < 40; t++) begin
            req_addr = rand_addr();
            if (req_ready) begin
                if (last_acc >= 0) check("accept_period", 32'(t - last_acc), 32'(LAT + 2));
                last_acc = t;
                cap      = req_addr;
                n_acc++;
            end
            step();
            if (resp_valid) begin
                check("stream_latency", 32'(t - last_acc), 32'(LAT));
                check("stream_data", resp_data, is_err(cap) ? NOP : ref_mem[cap[9:2]]);
                check("stream_err", 32'(resp_err), 32'(is_err(cap)));
            end
        end
        check("stream_accepts", 32'(n_acc), 32'(40 / (LAT + 2)));
        req_valid = 1'b0;
        idle = 1'b0;
        for (int k = 0; k < 20 && !idle; k++) begin
            step();
            idle = req_ready;
        end
        check("stream_drain_idle", 32'(idle), 32'd1);
        resp_ready = 1'b0;

        // Reset in the middle of the wait must drop the pending response.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0010;
        step();
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midwait_rst_ready", 32'(req_ready), 32'd1);
        check("midwait_rst_valid", 32'(resp_valid), 32'd0);
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("post_rst_no_resp", 32'(resp_valid), 32'd0);
        end
        txn(32'h0000_000C, 0);
        txn(32'h0000_0010, 0);
        txn(32'h0000_03FC, 1);

        // LATENCY=1 instance: a load on the read edge returns the old word.
        old_w = 32'hAAAA_5555;
        new_w = 32'h1234_ABCD;
        load_en = 1'b1; load_addr = 32'h0000_0014; load_data = old_w;
        step();
        check("l1_idle", 32'(req_ready1), 32'd1);
        req_valid1 = 1'b1; req_addr1 = 32'h0000_0014;
        step();
        req_valid1 = 1'b0; req_addr1 = 32'h0000_0008;
        load_en = 1'b1; load_addr = 32'h0000_0014; load_data = new_w;
        step();
        check("l1_resp_valid", 32'(resp_valid1), 32'd1);
        check("l1_old_data", resp_data1, old_w);
        check("l1_err", 32'(resp_err1), 32'd0);
        resp_ready1 = 1'b1;
        step();
        resp_ready1 = 1'b0;
        check("l1_back_idle", 32'(req_ready1), 32'd1);
        req_valid1 = 1'b1; req_addr1 = 32'h0000_0014;
        step();
        req_valid1 = 1'b0;
        step();
        check("l1_resp_valid2", 32'(resp_valid1), 32'd1);
        check("l1_new_data", resp_data1, new_w);
        resp_ready1 = 1'b1;
        step();
        resp_ready1 = 1'b0;

        txn(32'h0000_0014, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
